// File: rtl/barrel_shifter.sv
// Registered barrel shifter: rotate/shift operand i by s through log2(WIDTH)
// mux stages, result captured into y one clock later.
module barrel_shifter #(
    parameter int WIDTH = 8,
    parameter int SW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       op,
    input  logic [SW-1:0]    s,
    input  logic [WIDTH-1:0] i,
    output logic [WIDTH-1:0] y,
    output logic             y_valid
);

    localparam logic [1:0] OP_ROL = 2'b00;
    localparam logic [1:0] OP_ROR = 2'b01;
    localparam logic [1:0] OP_SLL = 2'b10;
    localparam logic [1:0] OP_SRA = 2'b11;

    // Handshake: en is a one-cycle request with no back-pressure; y_valid
    // pulses high on the cycle after each edge that captured with en=1.
    logic [WIDTH-1:0] w_x;
    logic [WIDTH-1:0] r_y;
    logic             r_valid;

    // Stage k moves the running value by 2^k when s[k] is set.
    always_comb begin
        w_x = i;
        for (int k = 0; k < SW; k++) begin
            if (s[k]) begin
                case (op)
                    OP_ROL:  w_x = (w_x << (1 << k)) | (w_x >> (WIDTH - (1 << k)));
                    OP_ROR:  w_x = (w_x >> (1 << k)) | (w_x << (WIDTH - (1 << k)));
                    OP_SLL:  w_x = w_x << (1 << k);
                    OP_SRA:  w_x = $signed(w_x) >>> (1 << k);
                    default: w_x = w_x;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_y     <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= en;
            if (en) begin
                r_y <= w_x;
            end
        end
    end

    assign y       = r_y;
    assign y_valid = r_valid;

endmodule

// File: tb/tb_barrel_shifter.sv
// Bench for barrel_shifter: directed vector table, reset/enable sequences,
// and random vectors checked against a per-bit index model.
module tb_barrel_shifter;

    localparam int W  = 8;
    localparam int SW = 3;

    logic          clk;
    logic          rst_n;
    logic          en;
    logic [1:0]    op;
    logic [SW-1:0] s;
    logic [W-1:0]  i;
    logic [W-1:0]  y;
    logic          y_valid;

    int n_tests;
    int n_fail;

    logic [W-1:0] exp_q[$];

    typedef struct {
        logic [1:0]    op;
        logic [SW-1:0] s;
        logic [W-1:0]  i;
        logic [W-1:0]  y;
    } vec_t;

    vec_t vecs[16];

    barrel_shifter #(.WIDTH(W), .SW(SW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .op      (op),
        .s       (s),
        .i       (i),
        .y       (y),
        .y_valid (y_valid)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: each output bit is picked from an input bit by index arithmetic.
    function automatic logic [W-1:0] ref_f(input logic [1:0] f_op, input int n,
                                           input logic [W-1:0] d);
        logic [W-1:0] r;
        r = '0;
        for (int b = 0; b < W; b++) begin
            case (f_op)
                2'b00:   r[b] = d[(b - n + W) % W];
                2'b01:   r[b] = d[(b + n) % W];
                2'b10:   r[b] = (b >= n) ? d[b - n] : 1'b0;
                default: r[b] = (b + n < W) ? d[b + n] : d[W-1];
            endcase
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // driver: set inputs at the falling edge, return 1 time unit after the rising edge
    task automatic drive(input logic d_en, input logic [1:0] d_op,
                         input logic [SW-1:0] d_s, input logic [W-1:0] d_i);
        @(negedge clk);
        en = d_en;
        op = d_op;
        s  = d_s;
        i  = d_i;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic       r_en;
        logic [1:0] r_op;
        logic [2:0] r_s;
        logic [7:0] r_i;
        logic [7:0] held;
        logic [7:0] e;

        n_tests = 0;
        n_fail  = 0;

        vecs[0]  = '{2'b00, 3'd0, 8'h62, 8'h62};
        vecs[1]  = '{2'b00, 3'd1, 8'h62, 8'hC4};
        vecs[2]  = '{2'b00, 3'd2, 8'h62, 8'h89};
        vecs[3]  = '{2'b00, 3'd3, 8'h62, 8'h13};
        vecs[4]  = '{2'b00, 3'd4, 8'h62, 8'h26};
        vecs[5]  = '{2'b00, 3'd5, 8'h62, 8'h4C};
        vecs[6]  = '{2'b00, 3'd6, 8'h62, 8'h98};
        vecs[7]  = '{2'b00, 3'd7, 8'h62, 8'h31};
        vecs[8]  = '{2'b01, 3'd1, 8'h62, 8'h31};
        vecs[9]  = '{2'b01, 3'd7, 8'h62, 8'hC4};
        vecs[10] = '{2'b10, 3'd3, 8'h62, 8'h10};
        vecs[11] = '{2'b10, 3'd7, 8'h62, 8'h00};
        vecs[12] = '{2'b11, 3'd2, 8'hA4, 8'hE9};
        vecs[13] = '{2'b11, 3'd7, 8'hA4, 8'hFF};
        vecs[14] = '{2'b11, 3'd4, 8'h62, 8'h06};
        vecs[15] = '{2'b10, 3'd7, 8'h01, 8'h80};

        rst_n = 1'b0;
        en    = 1'b0;
        op    = 2'b00;
        s     = '0;
        i     = '0;
        #3;
        chk("reset_y", y, 8'h00);
        chk("reset_valid", {7'd0, y_valid}, 8'h00);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // directed table
        foreach (vecs[k]) begin
            drive(1'b1, vecs[k].op, vecs[k].s, vecs[k].i);
            chk($sformatf("vec%0d_y", k), y, vecs[k].y);
            chk($sformatf("vec%0d_valid", k), {7'd0, y_valid}, 8'h01);
        end

        // asynchronous reset mid-cycle with y=0xC4
        drive(1'b1, 2'b00, 3'd1, 8'h62);
        chk("pre_reset_y", y, 8'hC4);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_y", y, 8'h00);
        chk("async_reset_valid", {7'd0, y_valid}, 8'h00);
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("reset_hold_y", y, 8'h00);
            chk("reset_hold_valid", {7'd0, y_valid}, 8'h00);
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 2'b01, 3'd1, 8'h62);
        chk("post_reset_y", y, 8'h31);
        chk("post_reset_valid", {7'd0, y_valid}, 8'h01);

        // enable hold
        drive(1'b1, 2'b00, 3'd4, 8'h62);
        chk("hold_capture_y", y, 8'h26);
        for (int c = 0; c < 3; c++) begin
            drive(1'b0, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                  8'($urandom_range(0, 255)));
            chk("hold_y", y, 8'h26);
            chk("hold_valid", {7'd0, y_valid}, 8'h00);
        end
        drive(1'b1, 2'b11, 3'd2, 8'hA4);
        chk("reenable_y", y, 8'hE9);
        chk("reenable_valid", {7'd0, y_valid}, 8'h01);

        // random vectors, scoreboard holds the expected register contents
        held = 8'hE9;
        for (int k = 0; k < 1000; k++) begin
            r_en = ($urandom_range(0, 3) != 0);
            r_op = 2'($urandom_range(0, 3));
            r_s  = (k % 8 == 0) ? 3'd0 : 3'($urandom_range(0, 7));
            r_i  = 8'($urandom_range(0, 255));
            if (r_en) begin
                held = ref_f(r_op, int'(r_s), r_i);
                if (r_s == 3'd0) begin
                    chk("model_s0", held, r_i);
                end
            end
            exp_q.push_back(held);
            drive(r_en, r_op, r_s, r_i);
            e = exp_q.pop_front();
            chk($sformatf("rand%0d_y", k), y, e);
            chk($sformatf("rand%0d_valid", k), {7'd0, y_valid}, {7'd0, r_en});
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

endmodule
